// File: rtl/eth_mii_receiver.sv
// eth_mii_receiver: 8-bit MII/GMII receive path.
// Strips the preamble and SFD, captures the MAC header, and streams the payload
// with the 4-byte FCS held back in a delay line. Checks the CRC-32 residue and
// the payload length, then reports one status pulse per frame.
module eth_mii_receiver #(
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500
) (
  input  logic        in_rxc,
  input  logic        in_rst_n,
  input  logic        in_rxdv,
  input  logic        in_rxer,
  input  logic [7:0]  in_rxd,
  output logic [47:0] out_dest_mac,
  output logic [47:0] out_src_mac,
  output logic [15:0] out_ether_type,
  output logic        out_hdr_valid,
  output logic [7:0]  out_data,
  output logic        out_data_valid,
  output logic        out_frame_done,
  output logic        out_frame_good,
  output logic        out_crc_err,
  output logic        out_len_err,
  output logic        out_rx_err,
  output logic [10:0] out_payload_len
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] MAX_LEN     = 11'(MAX_PAYLOAD);
  localparam logic [10:0] MIN_LEN     = 11'(MIN_PAYLOAD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_PAY,
    S_DROP
  } state_t;

  state_t          r_state;
  logic [31:0]     r_crc;
  logic [2:0]      r_pre_cnt;   // preamble octets seen so far
  logic [10:0]     r_cnt;       // header index, then emitted payload count
  logic [2:0]      r_fill;      // occupancy of the FCS delay line
  logic [3:0][7:0] r_dly;       // [3] is the oldest byte
  logic            r_trunc;     // payload exceeded MAX_PAYLOAD
  logic            r_rxer_seen; // PHY error since SFD
  logic [47:0]     r_dest;
  logic [47:0]     r_src;
  logic [15:0]     r_type;
  logic            r_hdr_valid;
  logic [7:0]      r_data;
  logic            r_data_valid;
  logic            r_frame_done;
  logic            r_frame_good;
  logic            r_crc_err;
  logic            r_len_err;
  logic            r_rx_err;
  logic [10:0]     r_payload_len;

  logic [31:0]     w_crc_next;
  logic            w_crc_bad;
  logic            w_short;

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] v;
    v = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      v = v[0] ? ((v >> 1) ^ CRC_POLY) : (v >> 1);
    return v;
  endfunction

  assign w_crc_next = crc_byte(r_crc, in_rxd);
  assign w_crc_bad  = (r_crc != CRC_RESIDUE);
  assign w_short    = (r_cnt < MIN_LEN);

  // Receive FSM: framing, header capture, payload delay line and status.
  always_ff @(posedge in_rxc or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state       <= S_IDLE;
      r_crc         <= 32'hFFFFFFFF;
      r_pre_cnt     <= '0;
      r_cnt         <= '0;
      r_fill        <= '0;
      r_dly         <= '0;
      r_trunc       <= 1'b0;
      r_rxer_seen   <= 1'b0;
      r_dest        <= '0;
      r_src         <= '0;
      r_type        <= '0;
      r_hdr_valid   <= 1'b0;
      r_data        <= '0;
      r_data_valid  <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_good  <= 1'b0;
      r_crc_err     <= 1'b0;
      r_len_err     <= 1'b0;
      r_rx_err      <= 1'b0;
      r_payload_len <= '0;
    end else begin
      r_hdr_valid  <= 1'b0;
      r_data_valid <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_rxdv) begin
            if (in_rxd == 8'h55) begin
              r_state   <= S_PRE;
              r_pre_cnt <= 3'd1;
            end else begin
              r_state <= S_DROP;
            end
          end
        end

        S_PRE: begin
          if (!in_rxdv) begin
            r_state <= S_IDLE;
          end else if (in_rxd == 8'hD5) begin
            r_state     <= S_HDR;
            r_crc       <= 32'hFFFFFFFF;
            r_cnt       <= '0;
            r_fill      <= '0;
            r_trunc     <= 1'b0;
            r_rxer_seen <= 1'b0;
          end else if (in_rxd == 8'h55 && r_pre_cnt != 3'd7) begin
            r_pre_cnt <= r_pre_cnt + 3'd1;
          end else begin
            r_state <= S_DROP;
          end
        end

        S_HDR: begin
          if (!in_rxdv) begin
            // Header cut short: report as both length and CRC failure.
            r_state       <= S_IDLE;
            r_frame_done  <= 1'b1;
            r_frame_good  <= 1'b0;
            r_crc_err     <= 1'b1;
            r_len_err     <= 1'b1;
            r_rx_err      <= r_rxer_seen;
            r_payload_len <= '0;
          end else begin
            r_crc <= w_crc_next;
            {r_dest, r_src, r_type} <= {r_dest[39:0], r_src, r_type, in_rxd};
            if (in_rxer) r_rxer_seen <= 1'b1;
            if (r_cnt == 11'd13) begin
              r_hdr_valid <= 1'b1;
              r_state     <= S_PAY;
              r_cnt       <= '0;
            end else begin
              r_cnt <= r_cnt + 11'd1;
            end
          end
        end

        S_PAY: begin
          if (!in_rxdv) begin
            r_state       <= S_IDLE;
            r_frame_done  <= 1'b1;
            r_crc_err     <= w_crc_bad;
            r_len_err     <= w_short | r_trunc;
            r_rx_err      <= r_rxer_seen;
            r_frame_good  <= ~(w_crc_bad | w_short | r_trunc | r_rxer_seen);
            r_payload_len <= r_cnt;
          end else begin
            r_crc <= w_crc_next;
            r_dly <= {r_dly[2:0], in_rxd};
            if (in_rxer) r_rxer_seen <= 1'b1;
            if (r_fill != 3'd4) begin
              r_fill <= r_fill + 3'd1;
            end else if (r_cnt == MAX_LEN) begin
              // Oversize: stop emitting and report once the frame ends.
              r_trunc <= 1'b1;
              r_state <= S_DROP;
            end else begin
              r_data       <= r_dly[3];
              r_data_valid <= 1'b1;
              if (r_cnt != 11'h7FF) r_cnt <= r_cnt + 11'd1;
            end
          end
        end

        S_DROP: begin
          if (in_rxdv) begin
            // Keep the CRC and error tracking alive for truncated frames.
            if (r_trunc) begin
              r_crc <= w_crc_next;
              if (in_rxer) r_rxer_seen <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
            if (r_trunc) begin
              r_trunc       <= 1'b0;
              r_frame_done  <= 1'b1;
              r_crc_err     <= w_crc_bad;
              r_len_err     <= 1'b1;
              r_rx_err      <= r_rxer_seen;
              r_frame_good  <= 1'b0;
              r_payload_len <= r_cnt;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_dest_mac    = r_dest;
  assign out_src_mac     = r_src;
  assign out_ether_type  = r_type;
  assign out_hdr_valid   = r_hdr_valid;
  assign out_data        = r_data;
  assign out_data_valid  = r_data_valid;
  assign out_frame_done  = r_frame_done;
  assign out_frame_good  = r_frame_good;
  assign out_crc_err     = r_crc_err;
  assign out_len_err     = r_len_err;
  assign out_rx_err      = r_rx_err;
  assign out_payload_len = r_payload_len;

endmodule

// File: tb/tb_eth_mii_receiver.sv
// Directed bench for eth_mii_receiver: table of whole frames plus hand-written
// preamble-fault, back-to-back and mid-frame reset sequences.
module tb_eth_mii_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxdv = 1'b0;
  logic        rxer = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic [47:0] dest_mac, src_mac;
  logic [15:0] ether_type;
  logic        hdr_valid, data_valid, frame_done, frame_good;
  logic        crc_err, len_err, rx_err;
  logic [7:0]  data;
  logic [10:0] payload_len;

  eth_mii_receiver #(.MIN_PAYLOAD(46), .MAX_PAYLOAD(1500)) dut (
    .in_rxc(clk), .in_rst_n(rst_n), .in_rxdv(rxdv), .in_rxer(rxer), .in_rxd(rxd),
    .out_dest_mac(dest_mac), .out_src_mac(src_mac), .out_ether_type(ether_type),
    .out_hdr_valid(hdr_valid), .out_data(data), .out_data_valid(data_valid),
    .out_frame_done(frame_done), .out_frame_good(frame_good),
    .out_crc_err(crc_err), .out_len_err(len_err), .out_rx_err(rx_err),
    .out_payload_len(payload_len)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor: counts pulses and records payload bytes and status at done.
  int         hdr_cnt = 0, done_cnt = 0, good_cnt = 0;
  logic [7:0] rxq[$];
  logic       st_good, st_crc, st_len, st_rx;
  logic [10:0] st_plen;
  always @(negedge clk) begin
    if (hdr_valid) hdr_cnt++;
    if (data_valid) rxq.push_back(data);
    if (frame_done) begin
      done_cnt++;
      if (frame_good) good_cnt++;
      st_good = frame_good; st_crc = crc_err; st_len = len_err;
      st_rx = rx_err; st_plen = payload_len;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] v;
    v = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
    return v;
  endfunction

  logic [7:0] frm[$];

  // Frame: npre x 55, sfd, broadcast header, payload i[7:0], FCS.
  task automatic build(input int plen, input bit bad_fcs, input int npre, input logic [7:0] sfd);
    logic [31:0] c;
    logic [7:0]  b;
    frm.delete();
    repeat (npre) frm.push_back(8'h55);
    frm.push_back(sfd);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 14 + plen; i++) begin
      if (i < 6)        b = 8'hFF;
      else if (i < 12)  b = 8'(17 * (i - 6));
      else if (i == 12) b = 8'h08;
      else if (i == 13) b = 8'h00;
      else              b = 8'(i - 14);
      frm.push_back(b);
      c = crc8(c, b);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) begin
      b = c[8*k +: 8];
      if (k == 0 && bad_fcs) b = b ^ 8'h01;
      frm.push_back(b);
    end
  endtask

  task automatic send(input int rxer_at);
    for (int i = 0; i < frm.size(); i++) begin
      @(posedge clk); #1;
      rxdv = 1'b1; rxd = frm[i]; rxer = (i == rxer_at);
    end
    @(posedge clk); #1;
    rxdv = 1'b0; rxer = 1'b0; rxd = 8'h00;
  endtask

  typedef struct {
    int plen; bit bad_fcs; int rxer_pay; bit chk_crc;
    int exp_len; bit exp_good; bit exp_crc; bit exp_lenerr; bit exp_rxerr;
  } vec_t;

  vec_t tbl[5];
  int   h0, d0, n0, g0, bad;

  initial begin
    tbl[0] = '{46,   1'b0, -1, 1'b1, 46,   1'b1, 1'b0, 1'b0, 1'b0}; // good min
    tbl[1] = '{46,   1'b1, -1, 1'b1, 46,   1'b0, 1'b1, 1'b0, 1'b0}; // bad FCS
    tbl[2] = '{20,   1'b0, -1, 1'b1, 20,   1'b0, 1'b0, 1'b1, 1'b0}; // runt
    tbl[3] = '{46,   1'b0, 10, 1'b1, 46,   1'b0, 1'b0, 1'b0, 1'b1}; // rxer
    tbl[4] = '{1510, 1'b0, -1, 1'b0, 1500, 1'b0, 1'b0, 1'b1, 1'b0}; // oversize

    #7;
    chk("rst_hdr",  {dest_mac, ether_type}, 64'h0);
    chk("rst_src",  {16'h0, src_mac}, 64'h0);
    chk("rst_stat", {data, data_valid, hdr_valid, frame_done, frame_good,
                     crc_err, len_err, rx_err, payload_len}, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int t = 0; t < 5; t++) begin
      h0 = hdr_cnt; d0 = rxq.size(); n0 = done_cnt;
      build(tbl[t].plen, tbl[t].bad_fcs, 7, 8'hD5);
      send(tbl[t].rxer_pay >= 0 ? 22 + tbl[t].rxer_pay : -1);
      repeat (3) @(posedge clk); #1;
      chk($sformatf("v%0d_hdrcnt", t), 64'(hdr_cnt - h0), 64'd1);
      chk($sformatf("v%0d_dest", t), 64'(dest_mac), 64'hFFFFFFFFFFFF);
      chk($sformatf("v%0d_src", t), 64'(src_mac), 64'h001122334455);
      chk($sformatf("v%0d_type", t), 64'(ether_type), 64'h0800);
      chk($sformatf("v%0d_ndata", t), 64'(rxq.size() - d0), 64'(tbl[t].exp_len));
      bad = 0;
      for (int i = 0; i < tbl[t].exp_len && d0 + i < rxq.size(); i++)
        if (rxq[d0 + i] !== 8'(i)) bad++;
      chk($sformatf("v%0d_data", t), 64'(bad), 64'd0);
      chk($sformatf("v%0d_done", t), 64'(done_cnt - n0), 64'd1);
      chk($sformatf("v%0d_good", t), 64'(st_good), 64'(tbl[t].exp_good));
      if (tbl[t].chk_crc) chk($sformatf("v%0d_crc", t), 64'(st_crc), 64'(tbl[t].exp_crc));
      chk($sformatf("v%0d_lenerr", t), 64'(st_len), 64'(tbl[t].exp_lenerr));
      chk($sformatf("v%0d_rxerr", t), 64'(st_rx), 64'(tbl[t].exp_rxerr));
      chk($sformatf("v%0d_plen", t), 64'(st_plen), 64'(tbl[t].exp_len));
      repeat (2) @(posedge clk);
    end

    // Preamble faults: eight 55s before SFD, then a corrupted SFD.
    h0 = hdr_cnt; d0 = rxq.size(); n0 = done_cnt;
    build(46, 1'b0, 8, 8'hD5); send(-1);
    repeat (3) @(posedge clk);
    build(46, 1'b0, 2, 8'hA5); send(-1);
    repeat (3) @(posedge clk); #1;
    chk("pre_hdr",  64'(hdr_cnt - h0), 64'd0);
    chk("pre_data", 64'(rxq.size() - d0), 64'd0);
    chk("pre_done", 64'(done_cnt - n0), 64'd0);
    build(46, 1'b0, 7, 8'hD5); send(-1);
    repeat (3) @(posedge clk); #1;
    chk("post_pre_done", 64'(done_cnt - n0), 64'd1);
    chk("post_pre_good", 64'(st_good), 64'd1);
    chk("post_pre_data", 64'(rxq.size() - d0), 64'd46);

    // Back-to-back good frames with one idle cycle.
    n0 = done_cnt; g0 = good_cnt;
    build(46, 1'b0, 7, 8'hD5);
    send(-1); send(-1);
    repeat (3) @(posedge clk); #1;
    chk("b2b_done", 64'(done_cnt - n0), 64'd2);
    chk("b2b_good", 64'(good_cnt - g0), 64'd2);

    // Reset while payload byte 20 is on the wire.
    build(46, 1'b0, 7, 8'hD5);
    n0 = done_cnt;
    for (int i = 0; i <= 42; i++) begin
      @(posedge clk); #1; rxdv = 1'b1; rxd = frm[i];
    end
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_hdr",  {dest_mac, ether_type}, 64'h0);
    chk("mrst_stat", {data, data_valid, hdr_valid, frame_done, frame_good,
                      crc_err, len_err, rx_err, payload_len}, 64'h0);
    d0 = rxq.size();
    for (int i = 43; i < frm.size(); i++) begin
      @(posedge clk); #1; rxd = frm[i];
      if (i == 45) rst_n = 1'b1;
    end
    @(posedge clk); #1; rxdv = 1'b0; rxd = 8'h00;
    repeat (4) @(posedge clk); #1;
    chk("mrst_done", 64'(done_cnt - n0), 64'd0);
    chk("mrst_data", 64'(rxq.size() - d0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
